imem_loader: RTL and testbench
==============================

# imem_loader

Boot-time instruction-memory loader upstream of the single-cycle MIPS core. Accepts a byte stream over a valid/ready handshake, assembles big-endian 32-bit words and writes them into the instruction memory at consecutive word addresses. Holds the CPU (PC and register file) frozen until a load completes. Guards against a stalled source with an inactivity timeout.

## Interface
Parameters:
- ADDR_W, 8, width of word index/base address (matches 8-bit first_addr)
- TIMEOUT, 1024, consecutive idle cycles in RECV before abort (>=2)

Ports:
- clk  in  1  system clock, rising edge
- clr  in  1  synchronous reset, active-low
- start  in  1  load request pulse; sampled only in IDLE/DONE/ERR
- base_addr  in  ADDR_W  word index of first word, latched on start
- word_count  in  ADDR_W+1  number of words to load, latched on start
- in_valid  in  1  source has a byte
- in_byte  in  8  stream byte, MSB-first within word
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  instruction-memory write strobe, one cycle per word
- mem_addr  out  32  byte address {zero-ext(base+idx), 2'b00}
- mem_wdata  out  32  assembled word
- cpu_hold  out  1  1 = CPU frozen; 0 only in DONE
- busy  out  1  1 in RECV/WRITE
- done  out  1  load completed, sticky until next start
- err  out  1  timeout abort, sticky until next start

## Operation
- States: IDLE, RECV, WRITE, DONE, ERR. All outputs registered.
- Reset (clr=0 at edge): state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, busy=0, done=0, err=0; byte index, word index, timeout counter, assembly register cleared. Reset mid-load discards the partial word; no write issued.
- IDLE/DONE/ERR + start: latch base_addr, word_count; clear done, err, indices, timeout. word_count==0 -> DONE next cycle (no writes); else -> RECV.
- start in RECV/WRITE ignored.
- RECV: in_ready=1. Handshake = in_valid & in_ready at edge: asm <= {asm[23:0], in_byte}, byte_idx++, timeout counter cleared. 4th accepted byte -> WRITE.
- RECV, no handshake: timeout counter++; reaching TIMEOUT -> ERR.
- WRITE (exactly one cycle): mem_we=1, mem_wdata=asm, mem_addr={ (base+word_idx) mod 2^ADDR_W, 2'b00 } zero-extended to 32 bits; in_ready=0. Then word_idx++; if word_idx+1==word_count -> DONE else RECV with byte_idx=0.
- Word index wraps modulo 2^ADDR_W; base+idx overflow wraps silently (no error).
- DONE: done=1, cpu_hold=0, busy=0, in_ready=0.
- ERR: err=1, cpu_hold=1, busy=0, in_ready=0; words already written stay written.
- cpu_hold=1 in every state except DONE.

## Timing
- Byte accepted at edge E when in_valid and in_ready both 1 before E.
- 4th byte accepted at edge E -> mem_we, mem_addr, mem_wdata valid in the cycle after E; memory captures at E+1; in_ready low that cycle, high again after E+1.
- Minimum 5 cycles per word; back-to-back stream sees in_ready drop one cycle per word.
- Last word's write cycle followed by done=1, cpu_hold=0 from the next edge.
- start accepted at edge S -> busy=1, in_ready=1 visible after S (first byte earliest at S+1).
- Timeout: TIMEOUT consecutive handshake-free RECV cycles -> err=1 after the TIMEOUT-th edge.
- clr overrides start and all handshakes at the same edge.

## Test plan
- Reset: hold clr=0 2 cycles with in_valid=1 -> all outputs at reset values, cpu_hold=1, no mem_we.
- Single word: base=0x10, count=1, bytes 8C,01,00,04 back-to-back -> one mem_we pulse, mem_addr=0x40, mem_wdata=0x8C010004; done=1, cpu_hold=0 next cycle.
- Three words with random in_valid gaps < TIMEOUT, base=0xFE -> addresses 0x3F8, 0x3FC, 0x000 (wrap), data in order, exactly 3 mem_we pulses.
- count=0 -> done=1 one cycle after start, zero writes, in_ready never high.
- Timeout: TIMEOUT=16, count=2, send 5 bytes then stall -> one write, err=1 after 16 idle cycles, cpu_hold stays 1; new start clears err.
- clr=0 after 2 bytes of a word, then restart -> no spurious write, first word assembled only from post-restart bytes; start pulse during RECV ignored.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write bus of the boot loader.
// The master modport is the loader side; slave is the source/memory side.
interface imem_loader_if;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    input  in_valid, in_byte,
    output in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_byte,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles big-endian words from a byte
// stream, writes them at consecutive word addresses and holds the CPU until done.
module imem_loader #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_count,
  imem_loader_if.master     bus,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE, ERR} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] base_q, base_next;
  logic [ADDR_W:0]   count_q, count_next;
  logic [1:0]        byte_idx, byte_next;
  logic [ADDR_W-1:0] word_idx, word_next;
  logic [CNT_W-1:0]  tmo_cnt, tmo_next;
  logic [31:0]       asm_q, asm_next;
  logic [31:0]       addr_next, wdata_next;
  logic              in_ready_next, mem_we_next, cpu_hold_next;
  logic              busy_next, done_next, err_next;
  logic              handshake;
  logic [ADDR_W-1:0] word_addr;
  logic [ADDR_W:0]   word_inc;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state         <= IDLE;
      base_q        <= '0;
      count_q       <= '0;
      byte_idx      <= '0;
      word_idx      <= '0;
      tmo_cnt       <= '0;
      asm_q         <= '0;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      state         <= state_next;
      base_q        <= base_next;
      count_q       <= count_next;
      byte_idx      <= byte_next;
      word_idx      <= word_next;
      tmo_cnt       <= tmo_next;
      asm_q         <= asm_next;
      bus.in_ready  <= in_ready_next;
      bus.mem_we    <= mem_we_next;
      bus.mem_addr  <= addr_next;
      bus.mem_wdata <= wdata_next;
      cpu_hold      <= cpu_hold_next;
      busy          <= busy_next;
      done          <= done_next;
      err           <= err_next;
    end
  end

  // Outputs are registered copies of decodes of the next state, so every
  // flag is valid in the same cycle the state it describes is entered.
  always_comb begin
    state_next = state;
    base_next  = base_q;
    count_next = count_q;
    byte_next  = byte_idx;
    word_next  = word_idx;
    tmo_next   = tmo_cnt;
    asm_next   = asm_q;
    addr_next  = bus.mem_addr;
    wdata_next = bus.mem_wdata;
    handshake  = bus.in_valid & bus.in_ready;
    word_addr  = base_q + word_idx;
    word_inc   = {1'b0, word_idx} + (ADDR_W + 1)'(1);

    case (state)
      IDLE, DONE, ERR: begin
        if (start) begin
          base_next  = base_addr;
          count_next = word_count;
          byte_next  = '0;
          word_next  = '0;
          tmo_next   = '0;
          asm_next   = '0;
          state_next = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        if (handshake) begin
          asm_next  = {asm_q[23:0], bus.in_byte};
          byte_next = byte_idx + 2'd1;
          tmo_next  = '0;
          if (byte_idx == 2'd3) begin
            state_next = WRITE;
            addr_next  = {{(30 - ADDR_W){1'b0}}, word_addr, 2'b00};
            wdata_next = {asm_q[23:0], bus.in_byte};
          end
        end else if (tmo_cnt == TMO_LAST) begin
          state_next = ERR;
        end else begin
          tmo_next = tmo_cnt + CNT_W'(1);
        end
      end
      WRITE: begin
        word_next  = word_idx + ADDR_W'(1);
        byte_next  = '0;
        state_next = (word_inc == count_q) ? DONE : RECV;
      end
      default: state_next = IDLE;
    endcase

    in_ready_next = (state_next == RECV);
    mem_we_next   = (state_next == WRITE);
    busy_next     = (state_next == RECV) || (state_next == WRITE);
    done_next     = (state_next == DONE);
    err_next      = (state_next == ERR);
    cpu_hold_next = (state_next != DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued by the stimulus
// and popped by an independent write monitor.
module tb_imem_loader;
  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  base_addr = '0;
  logic [8:0]  word_count = '0;
  logic        cpu_hold, busy, done, err;

  int vectors = 0;
  int miscompares = 0;
  int writes = 0;
  logic [63:0] exp_q[$];

  imem_loader_if bus();

  imem_loader #(.ADDR_W(8), .TIMEOUT(16)) dut (
    .clk(clk), .clr(clr), .start(start), .base_addr(base_addr),
    .word_count(word_count), .bus(bus), .cpu_hold(cpu_hold),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every cycle with mem_we must match the oldest expected write.
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      writes++;
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_write: got addr %h data %h expected no write",
                 bus.mem_addr, bus.mem_wdata);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check_output("write_addr", bus.mem_addr, e[63:32]);
        check_output("write_data", bus.mem_wdata, e[31:0]);
      end
    end
  end

  task automatic apply_stimulus(input logic [7:0] b, input logic [7:0] base, input logic [8:0] cnt);
    @(posedge clk); #1;
    start = 1'b1;
    base_addr = b == 8'h00 ? base : base;
    word_count = cnt;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_byte  = b;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL handshake_timeout: got in_ready low for 50 cycles expected acceptance of %h", b);
    end
  endtask

  task automatic send_word(input logic [31:0] w, input int max_gap);
    for (int k = 3; k >= 0; k--) begin
      repeat ($urandom_range(0, max_gap)) @(posedge clk);
      #1;
      send_byte(w[k*8 +: 8]);
    end
  endtask

  initial begin
    bus.in_valid = 1'b1;
    bus.in_byte  = 8'h5A;

    // Reset with in_valid asserted
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check_output("rst_mem_addr", bus.mem_addr, 32'h0);
    check_output("rst_mem_wdata", bus.mem_wdata, 32'h0);
    check_output("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err", 32'(err), 32'd0);
    bus.in_valid = 1'b0;
    clr = 1'b1;

    // Single word at base 0x10
    exp_q.push_back({32'h0000_0040, 32'h8C01_0004});
    apply_stimulus(8'h01, 8'h10, 9'd1);
    check_output("start_busy", 32'(busy), 32'd1);
    check_output("start_in_ready", 32'(bus.in_ready), 32'd1);
    send_byte(8'h8C); send_byte(8'h01); send_byte(8'h00); send_byte(8'h04);
    check_output("w1_mem_we", 32'(bus.mem_we), 32'd1);
    check_output("w1_in_ready_low", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check_output("w1_done", 32'(done), 32'd1);
    check_output("w1_cpu_hold", 32'(cpu_hold), 32'd0);
    check_output("w1_busy", 32'(busy), 32'd0);
    check_output("w1_writes", 32'(writes), 32'd1);

    // Three words with gaps, address wraps past 0xFF
    exp_q.push_back({32'h0000_03F8, 32'h0123_4567});
    exp_q.push_back({32'h0000_03FC, 32'h89AB_CDEF});
    exp_q.push_back({32'h0000_0000, 32'hDEAD_BEEF});
    apply_stimulus(8'h01, 8'hFE, 9'd3);
    check_output("w3_cpu_hold_busy", 32'(cpu_hold), 32'd1);
    send_word(32'h0123_4567, 5);
    send_word(32'h89AB_CDEF, 5);
    send_word(32'hDEAD_BEEF, 5);
    @(posedge clk); #1;
    check_output("w3_done", 32'(done), 32'd1);
    check_output("w3_writes", 32'(writes), 32'd4);

    // Zero-length load
    apply_stimulus(8'h01, 8'h33, 9'd0);
    check_output("c0_done", 32'(done), 32'd1);
    check_output("c0_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("c0_busy", 32'(busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    check_output("c0_writes", 32'(writes), 32'd4);

    // Timeout after one word plus a stray byte
    exp_q.push_back({32'h0000_0080, 32'hCAFE_F00D});
    apply_stimulus(8'h01, 8'h20, 9'd2);
    send_word(32'hCAFE_F00D, 0);
    send_byte(8'h99);
    repeat (15) @(posedge clk);
    #1;
    check_output("tmo_err_early", 32'(err), 32'd0);
    @(posedge clk); #1;
    check_output("tmo_err", 32'(err), 32'd1);
    check_output("tmo_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("tmo_busy", 32'(busy), 32'd0);
    check_output("tmo_writes", 32'(writes), 32'd5);

    // New start clears err; reset mid-word discards partial data
    apply_stimulus(8'h01, 8'h00, 9'd1);
    check_output("restart_err_clr", 32'(err), 32'd0);
    check_output("restart_busy", 32'(busy), 32'd1);
    send_byte(8'hAA); send_byte(8'hBB);
    clr = 1'b0;
    @(posedge clk); #1;
    clr = 1'b1;
    check_output("midrst_busy", 32'(busy), 32'd0);
    check_output("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    check_output("midrst_cpu_hold", 32'(cpu_hold), 32'd1);
    check_output("midrst_mem_we", 32'(bus.mem_we), 32'd0);

    // Restart; a start pulse during RECV must be ignored
    exp_q.push_back({32'h0000_0014, 32'h1122_3344});
    apply_stimulus(8'h01, 8'h05, 9'd1);
    send_byte(8'h11);
    start = 1'b1; base_addr = 8'h77; word_count = 9'd3;
    @(posedge clk); #1;
    start = 1'b0;
    send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    @(posedge clk); #1;
    check_output("rs_done", 32'(done), 32'd1);
    check_output("rs_cpu_hold", 32'(cpu_hold), 32'd0);

    repeat (3) @(posedge clk); #1;
    check_output("total_writes", 32'(writes), 32'd6);
    check_output("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
